count_disp: RTL and testbench

- Downstream consumer of the traffic controller's main-road countdown (count) and country-road countdown (count_c).
- Converts both 8-bit binary values to two-digit BCD with a sequential shift-add-3 engine.
- Drives a 4-digit multiplexed common-anode 7-segment display: main tens, main units, country tens, country units.
- Registered outputs, single clock domain.

---
 rtl/traffic_disp_pkg.sv | 68 ++++++
 rtl/bin2bcd_seq.sv | 38 +++
 rtl/count_disp.sv | 139 +++++++++++++
 tb/tb_count_disp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_disp_pkg.sv
// Shared constants for the countdown display: segment codes,
// digit codes, conversion FSM states and digit mapping helpers.
package traffic_disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-numeric digit codes held in the display registers
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    localparam logic [3:0] CONV_BITS = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:     s = SEG_0;
            4'd1:     s = SEG_1;
            4'd2:     s = SEG_2;
            4'd3:     s = SEG_3;
            4'd4:     s = SEG_4;
            4'd5:     s = SEG_5;
            4'd6:     s = SEG_6;
            4'd7:     s = SEG_7;
            4'd8:     s = SEG_8;
            4'd9:     s = SEG_9;
            DIG_DASH: s = SEG_DASH;
            default:  s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Returns {tens_code, units_code} for one BCD value
    function automatic logic [7:0] digit_pair(
        input logic [3:0] h,
        input logic [3:0] t,
        input logic [3:0] u,
        input logic       lzb
    );
        logic [7:0] p;
        if (h != 4'd0)
            p = {DIG_DASH, DIG_DASH};
        else if (lzb && t == 4'd0)
            p = {DIG_BLANK, u};
        else
            p = {t, u};
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-nibble BCD shift-add-3 engine.
// Ports: clk, set_n, load (capture bin), step (one shift), hund/tens/units.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       set_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] bin,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    // {hundreds, tens, units, binary}
    logic [19:0] sr;
    logic [19:0] adj;

    always_comb begin
        adj = sr;
        if (sr[19:16] >= 4'd5) adj[19:16] = sr[19:16] + 4'd3;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n)
            sr <= '0;
        else if (load)
            sr <= {12'd0, bin};
        else if (step)
            sr <= {adj[18:0], 1'b0};
    end

    assign hund  = sr[19:16];
    assign tens  = sr[15:12];
    assign units = sr[11:8];

endmodule

// File: rtl/count_disp.sv
// Two-value countdown display: BCD conversion FSM plus 4-digit scan.
// Ports: clk, set_n, count, count_c in; seg, dig, conv_busy out.
module count_disp
    import traffic_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          LZB      = 1'b1
) (
    input  logic       clk,
    input  logic       set_n,
    input  logic [7:0] count,
    input  logic [7:0] count_c,
    output logic [6:0] seg,
    output logic [3:0] dig,
    output logic       conv_busy
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t           state;
    state_t           state_nx;
    logic [7:0]       cap_m;
    logic [7:0]       cap_c;
    logic [3:0]       bit_cnt;
    logic             load;
    logic             step;
    logic [3:0][3:0]  digs;
    logic [15:0]      scan_cnt;
    logic [1:0]       scan_idx;

    logic [3:0] m_h, m_t, m_u;
    logic [3:0] c_h, c_t, c_u;
    logic [7:0] m_pair, c_pair;

    bin2bcd_seq u_main (
        .clk   (clk),
        .set_n (set_n),
        .load  (load),
        .step  (step),
        .bin   (count),
        .hund  (m_h),
        .tens  (m_t),
        .units (m_u)
    );

    bin2bcd_seq u_country (
        .clk   (clk),
        .set_n (set_n),
        .load  (load),
        .step  (step),
        .bin   (count_c),
        .hund  (c_h),
        .tens  (c_t),
        .units (c_u)
    );

    assign m_pair = digit_pair(m_h, m_t, m_u, LZB);
    assign c_pair = digit_pair(c_h, c_t, c_u, LZB);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            ST_IDLE:
                if ({count, count_c} != {cap_m, cap_c})
                    state_nx = ST_LOAD;
            ST_LOAD: begin
                load     = 1'b1;
                state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (bit_cnt == 4'd1)
                    state_nx = ST_COMMIT;
            end
            ST_COMMIT:
                state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            state     <= ST_LOAD;
            cap_m     <= '0;
            cap_c     <= '0;
            bit_cnt   <= '0;
            conv_busy <= 1'b0;
            digs      <= {4{DIG_BLANK}};
        end else begin
            state <= state_nx;
            unique case (state)
                ST_LOAD: begin
                    cap_m     <= count;
                    cap_c     <= count_c;
                    bit_cnt   <= CONV_BITS;
                    conv_busy <= 1'b1;
                end
                ST_SHIFT:
                    bit_cnt <= bit_cnt - 4'd1;
                ST_COMMIT: begin
                    // all four digits land together: no torn pair
                    digs[0]   <= m_pair[7:4];
                    digs[1]   <= m_pair[3:0];
                    digs[2]   <= c_pair[7:4];
                    digs[3]   <= c_pair[3:0];
                    conv_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Digit scan runs free of the conversion FSM
    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            seg <= SEG_BLANK;
            dig <= 4'hF;
        end else begin
            seg <= seg_of(digs[scan_idx]);
            dig <= ~(4'b0001 << scan_idx);
        end
    end

endmodule

// File: tb/tb_count_disp.sv
// Scoreboard bench for count_disp: conversion latency, digit mapping,
// scan sequencing, mid-conversion changes and asynchronous reset.
module tb_count_disp;

    logic       clk = 1'b0;
    logic       set_n;
    logic [7:0] count;
    logic [7:0] count_c;
    logic [6:0] seg, seg2;
    logic [3:0] dig, dig2;
    logic       busy, busy2;

    int vectors = 0;
    int errors  = 0;
    int edge_no = 0;
    logic busy_q = 1'b0;
    int falls[$];
    logic [27:0] sb[$];

    always #5 clk = ~clk;

    count_disp #(.SCAN_DIV(4), .LZB(1'b1)) dut (
        .clk(clk), .set_n(set_n), .count(count), .count_c(count_c),
        .seg(seg), .dig(dig), .conv_busy(busy)
    );

    count_disp #(.SCAN_DIV(4), .LZB(1'b0)) dut2 (
        .clk(clk), .set_n(set_n), .count(count), .count_c(count_c),
        .seg(seg2), .dig(dig2), .conv_busy(busy2)
    );

    // Edge counter and log of conv_busy falling edges
    always @(posedge clk) begin
        edge_no++;
        #1;
        if (busy_q && !busy) falls.push_back(edge_no);
        busy_q = busy;
    end

    function automatic logic [6:0] sref(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] pair(int v, bit lzb);
        int t, u;
        if (v > 99) return {7'b0111111, 7'b0111111};
        t = v / 10;
        u = v % 10;
        return {sref(u), (lzb && t == 0) ? 7'b1111111 : sref(t)};
    endfunction

    // Packed {c units, c tens, m units, m tens}, 7 bits each
    function automatic logic [27:0] exp_of(int m, int c, bit lzb);
        return {pair(c, lzb), pair(m, lzb)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_falls(int n);
        for (int i = 0; i < 60 && falls.size() < n; i++) tick();
        vectors++;
        if (falls.size() < n) begin
            errors++;
            $display("FAIL conv_done_timeout: got %0d falls, need %0d",
                     falls.size(), n);
        end
    endtask

    task automatic check_display(int n, bit sel);
        logic [27:0] e;
        logic [3:0]  d, nd;
        logic [6:0]  s;
        int          idx;
        e = sb.pop_front();
        for (int i = 0; i < n; i++) begin
            tick();
            d  = sel ? dig2 : dig;
            s  = sel ? seg2 : seg;
            nd = ~d;
            vectors++;
            if (!$onehot(nd)) begin
                errors++;
                $display("FAIL dig_onehot dut%0d: got %b need one-hot low",
                         sel, d);
            end else begin
                idx = 0;
                for (int j = 0; j < 4; j++) if (nd[j]) idx = j;
                vectors++;
                if (s !== e[idx*7 +: 7]) begin
                    errors++;
                    $display("FAIL seg dut%0d dig%0d: got %b need %b",
                             sel, idx, s, e[idx*7 +: 7]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [27:0] e;
        logic [3:0]  ed;
        logic [6:0]  es;
        int          base, k, idx;
        set_n   = 1'b0;
        count   = 8'd25;
        count_c = 8'd30;
        sb.push_back(exp_of(25, 30, 1'b1));
        e = '0;
        tick();
        tick();
        vectors += 3;
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL rst_seg: got %h need 7f", seg);
        end
        if (dig !== 4'hF) begin
            errors++;
            $display("FAIL rst_dig: got %h need f", dig);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b need 0", busy);
        end
        set_n = 1'b1;
        base  = edge_no;
        for (k = 1; k <= 26; k++) begin
            tick();
            if (k == 11) e = sb.pop_front();
            if (k == 1 || k == 9 || k == 10) begin
                vectors++;
                if (busy !== (k != 10)) begin
                    errors++;
                    $display("FAIL busy_edge%0d: got %b need %b",
                             k, busy, (k != 10));
                end
            end
            idx = ((k - 1) / 4) % 4;
            ed  = ~(4'b0001 << idx);
            es  = (k <= 10) ? 7'h7F : e[idx*7 +: 7];
            vectors += 2;
            if (dig !== ed) begin
                errors++;
                $display("FAIL scan_dig edge%0d: got %b need %b", k, dig, ed);
            end
            if (seg !== es) begin
                errors++;
                $display("FAIL scan_seg edge%0d: got %b need %b", k, seg, es);
            end
        end
        if (edge_no != base + 26) $display("note: edge count drift");
    endtask

    task automatic test_change();
        int e;
        falls.delete();
        e = edge_no;
        count = 8'd24;
        sb.push_back(exp_of(24, 30, 1'b1));
        wait_falls(1);
        vectors++;
        if (falls.size() < 1 || falls[0] != e + 11) begin
            errors++;
            $display("FAIL change_latency: commit edge %0d need %0d",
                     falls.size() ? falls[0] : -1, e + 11);
        end
        check_display(16, 1'b0);
    endtask

    task automatic test_table();
        int m_v[6] = '{5, 5, 99, 0, 100, 10};
        int c_v[6] = '{0, 150, 99, 255, 9, 200};
        for (int i = 0; i < 6; i++) begin
            falls.delete();
            count   = 8'(m_v[i]);
            count_c = 8'(c_v[i]);
            sb.push_back(exp_of(m_v[i], c_v[i], 1'b1));
            sb.push_back(exp_of(m_v[i], c_v[i], 1'b0));
            wait_falls(1);
            check_display(16, 1'b0);
            check_display(16, 1'b1);
        end
    endtask

    task automatic test_mid_change();
        int e;
        falls.delete();
        e = edge_no;
        count   = 8'd37;
        count_c = 8'd30;
        sb.push_back(exp_of(37, 30, 1'b1));
        sb.push_back(exp_of(61, 30, 1'b1));
        for (int i = 0; i < 4; i++) tick();
        count = 8'd61;
        wait_falls(1);
        check_display(10, 1'b0);
        wait_falls(2);
        vectors += 2;
        if (falls.size() < 1 || falls[0] != e + 11) begin
            errors++;
            $display("FAIL mid_first_commit: got %0d need %0d",
                     falls.size() ? falls[0] : -1, e + 11);
        end
        if (falls.size() < 2 || falls[1] != e + 22) begin
            errors++;
            $display("FAIL mid_recommit: got %0d need %0d",
                     falls.size() > 1 ? falls[1] : -1, e + 22);
        end
        check_display(16, 1'b0);
    endtask

    task automatic test_reset_mid();
        int base;
        count = 8'd42;
        for (int i = 0; i < 4; i++) tick();
        #3;
        set_n = 1'b0;
        #1;
        vectors += 3;
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL async_rst_seg: got %h need 7f", seg);
        end
        if (dig !== 4'hF) begin
            errors++;
            $display("FAIL async_rst_dig: got %h need f", dig);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_busy: got %b need 0", busy);
        end
        count_c = 8'd77;
        tick();
        tick();
        vectors++;
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL held_rst_seg: got %h need 7f", seg);
        end
        set_n = 1'b1;
        base  = edge_no;
        falls.delete();
        sb.push_back(exp_of(42, 77, 1'b1));
        wait_falls(1);
        vectors++;
        if (falls.size() < 1 || falls[0] != base + 10) begin
            errors++;
            $display("FAIL rst_release_commit: got %0d need %0d",
                     falls.size() ? falls[0] : -1, base + 10);
        end
        check_display(16, 1'b0);
    endtask

    initial begin
        test_reset();
        test_change();
        test_table();
        test_mid_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
